game_screen_overlay: RTL and testbench

- Parametrised successor to the static end-of-game text overlay.
- Renders a mode-selectable title banner plus a blinking "Press any key to start" prompt.
- The title slides down into position on entry.
- Key presses are ignored for an arming window, then a key dismisses the screen with a one-cycle pulse to the game FSM.
- Sits in the video path beside the ball/paddle renderers; its in_text output feeds the pixel colour mux.

---
 rtl/game_screen_overlay.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_game_screen_overlay.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_screen_overlay.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// string_display
//   Renders a fixed text string with a 5x7 font in a 6x8 cell, each font
//   pixel magnified to SCALE x SCALE screen pixels, KERNING extra columns
//   between glyph cells. The horizontal origin is fixed at elaboration and
//   may be negative (text clipped at the left edge); the vertical origin is
//   a live input so the caller can animate it.
//   Ports:
//     pixel_x, pixel_y  current beam position
//     y_pos             top row of the text block
//     pixel_on          combinational: beam is on a lit font pixel
// ---------------------------------------------------------------------------
module string_display #(
  parameter int LEN = 1,
  parameter int SCALE = 1,
  parameter int KERNING = 0,
  parameter int X_POS = 0,
  parameter logic [8*LEN-1:0] TEXT = '0
) (
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [9:0] y_pos,
  output logic       pixel_on
);
  localparam int PITCH  = 6 * SCALE + KERNING;
  localparam int HEIGHT = 8 * SCALE;
  localparam int IW     = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic signed [12:0] X_S = 13'(X_POS);
  localparam logic signed [12:0] W_S = 13'(LEN * PITCH);

  // First character of the string sits in the most significant byte.
  logic [7:0] chars [LEN];
  for (genvar i = 0; i < LEN; i++) begin : g_chars
    assign chars[i] = TEXT[8*(LEN-1-i) +: 8];
  end

  // Rows top to bottom, each row 5 bits with the leftmost column as MSB.
  function automatic logic [34:0] glyph(input logic [7:0] c);
    case (c)
      "!": return 35'b00100_00100_00100_00100_00100_00000_00100;
      "1": return 35'b00100_01100_00100_00100_00100_00100_01110;
      "2": return 35'b01110_10001_00001_00010_00100_01000_11111;
      "G": return 35'b01110_10001_10000_10111_10001_10001_01111;
      "P": return 35'b11110_10001_10001_11110_10000_10000_10000;
      "a": return 35'b00000_00000_01110_00001_01111_10001_01111;
      "d": return 35'b00001_00001_01101_10011_10001_10001_01111;
      "e": return 35'b00000_00000_01110_10001_11111_10000_01110;
      "i": return 35'b00100_00000_01100_00100_00100_00100_01110;
      "k": return 35'b10000_10000_10010_10100_11000_10100_10010;
      "l": return 35'b01100_00100_00100_00100_00100_00100_01110;
      "m": return 35'b00000_00000_11010_10101_10101_10001_10001;
      "n": return 35'b00000_00000_10110_11001_10001_10001_10001;
      "o": return 35'b00000_00000_01110_10001_10001_10001_01110;
      "r": return 35'b00000_00000_10110_11001_10000_10000_10000;
      "s": return 35'b00000_00000_01110_10000_01110_00001_11110;
      "t": return 35'b01000_01000_11100_01000_01000_01001_00110;
      "u": return 35'b00000_00000_10001_10001_10001_10011_01101;
      "v": return 35'b00000_00000_10001_10001_10001_01010_00100;
      "w": return 35'b00000_00000_10001_10001_10101_10101_01010;
      "y": return 35'b00000_00000_10001_10001_01111_00001_01110;
      default: return 35'd0;
    endcase
  endfunction

  logic signed [12:0] dx;
  logic [10:0]        dy;
  logic               in_x;
  logic               in_y;
  int                 xo;
  int                 yo;
  int                 col;
  int                 row;
  logic [IW-1:0]      cidx;
  logic [34:0]        g;
  logic [5:0]         bit_idx;

  always_comb begin
    pixel_on = 1'b0;
    // Signed x offset so a string wider than the screen clips cleanly.
    dx       = $signed({3'b000, pixel_x}) - X_S;
    dy       = {1'b0, pixel_y} - {1'b0, y_pos};
    in_x     = (dx >= 13'sd0) && (dx < W_S);
    in_y     = (pixel_y >= y_pos) && (dy < 11'(HEIGHT));
    xo       = int'(dx);
    yo       = int'(dy);
    col      = (xo % PITCH) / SCALE;
    row      = yo / SCALE;
    cidx     = '0;
    g        = '0;
    bit_idx  = '0;
    if (in_x && in_y) begin
      cidx = IW'(xo / PITCH);
      g    = glyph(chars[cidx]);
      // Column 5, row 7 and any kerning gap are inter-glyph spacing.
      if (col < 5 && row < 7) begin
        bit_idx  = 6'(34 - (row * 5 + col));
        pixel_on = g[bit_idx];
      end
    end
  end
endmodule

// ---------------------------------------------------------------------------
// game_screen_overlay
//   Title banner (one of four, chosen by mode at entry) that slides down to
//   TITLE_Y, plus a blinking "Press any key to start" prompt. After an arming
//   window a key press dismisses the screen with a one-cycle pulse.
//   Ports:
//     clk_0, rst          pixel clock, async active-high reset
//     pixel_x, pixel_y    current beam position
//     frame_tick          one-cycle strobe per frame
//     show                level request to display the screen
//     mode                title select (0..3)
//     key_press           one-cycle strobe per key-down
//     in_text             registered: current pixel is lit text
//     active              screen FSM is not IDLE
//     dismissed           one-cycle pulse when a key is accepted
//   frame_tick and key_press are single-cycle strobes sampled on clk_0; a
//   strobe held for several cycles counts once per cycle. show is a level
//   and dropping it always wins over a key in the same cycle.
// ---------------------------------------------------------------------------
module game_screen_overlay #(
  parameter int KERNING       = 0,
  parameter int TITLE_SCALE   = 8,
  parameter int PROMPT_SCALE  = 3,
  parameter int TITLE_Y       = 99,
  parameter int PROMPT_Y      = TITLE_Y + 8 * TITLE_SCALE + 19,
  parameter int SLIDE_START_Y = 0,
  parameter int SLIDE_STEP    = 4,
  parameter int BLINK_FRAMES  = 30,
  parameter int ARM_FRAMES    = 60
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       frame_tick,
  input  logic       show,
  input  logic [1:0] mode,
  input  logic       key_press,
  output logic       in_text,
  output logic       active,
  output logic       dismissed
);
  // Centre each string on a 640-wide screen (6-column cells).
  localparam int X_T0 = 320 - 3 * 10 * TITLE_SCALE - ((10 - 1) * KERNING) / 2;
  localparam int X_T1 = 320 - 3 * 14 * TITLE_SCALE - ((14 - 1) * KERNING) / 2;
  localparam int X_T2 = 320 - 3 * 14 * TITLE_SCALE - ((14 - 1) * KERNING) / 2;
  localparam int X_T3 = 320 - 3 * 6 * TITLE_SCALE - ((6 - 1) * KERNING) / 2;
  localparam int X_PR = 320 - 66 * PROMPT_SCALE - (21 * KERNING) / 2;

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int AW = (ARM_FRAMES > 0) ? $clog2(ARM_FRAMES + 1) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [AW-1:0] ARM_TGT    = AW'(ARM_FRAMES);
  localparam logic          SKIP_SLIDE = (SLIDE_START_Y >= TITLE_Y);
  localparam logic          ARM_AT_ENTRY = (ARM_FRAMES == 0);

  typedef enum logic [1:0] {IDLE, SLIDE, SHOW} state_t;

  state_t        state, state_nx;
  logic [9:0]    title_y, title_y_nx;
  logic [BW-1:0] blink_cnt, blink_cnt_nx;
  logic          blink_on, blink_on_nx;
  logic [AW-1:0] arm_cnt, arm_cnt_nx;
  logic          armed, armed_nx;
  logic [1:0]    mode_q, mode_nx;
  logic          dismissed_nx;
  logic          enter_show;
  logic [10:0]   step_sum;

  logic [3:0]    title_pix_v;
  logic          title_pix;
  logic          prompt_pix;
  logic          prompt_en;

  string_display #(.LEN(10), .SCALE(TITLE_SCALE), .KERNING(KERNING), .X_POS(X_T0),
    .TEXT("Game over!")) u_title0 (.pixel_x(pixel_x), .pixel_y(pixel_y),
    .y_pos(title_y), .pixel_on(title_pix_v[0]));
  string_display #(.LEN(14), .SCALE(TITLE_SCALE), .KERNING(KERNING), .X_POS(X_T1),
    .TEXT("Player 1 wins!")) u_title1 (.pixel_x(pixel_x), .pixel_y(pixel_y),
    .y_pos(title_y), .pixel_on(title_pix_v[1]));
  string_display #(.LEN(14), .SCALE(TITLE_SCALE), .KERNING(KERNING), .X_POS(X_T2),
    .TEXT("Player 2 wins!")) u_title2 (.pixel_x(pixel_x), .pixel_y(pixel_y),
    .y_pos(title_y), .pixel_on(title_pix_v[2]));
  string_display #(.LEN(6), .SCALE(TITLE_SCALE), .KERNING(KERNING), .X_POS(X_T3),
    .TEXT("Paused")) u_title3 (.pixel_x(pixel_x), .pixel_y(pixel_y),
    .y_pos(title_y), .pixel_on(title_pix_v[3]));
  string_display #(.LEN(22), .SCALE(PROMPT_SCALE), .KERNING(KERNING), .X_POS(X_PR),
    .TEXT("Press any key to start")) u_prompt (.pixel_x(pixel_x), .pixel_y(pixel_y),
    .y_pos(10'(PROMPT_Y)), .pixel_on(prompt_pix));

  assign title_pix = title_pix_v[mode_q];
  assign prompt_en = (state == SHOW) && blink_on;
  assign active    = (state != IDLE);

  always_comb begin
    state_nx     = state;
    title_y_nx   = title_y;
    blink_cnt_nx = blink_cnt;
    blink_on_nx  = blink_on;
    arm_cnt_nx   = arm_cnt;
    armed_nx     = armed;
    mode_nx      = mode_q;
    dismissed_nx = 1'b0;
    enter_show   = 1'b0;
    step_sum     = '0;
    case (state)
      IDLE: begin
        if (show) begin
          mode_nx = mode;
          if (SKIP_SLIDE) begin
            title_y_nx = 10'(TITLE_Y);
            state_nx   = SHOW;
            enter_show = 1'b1;
          end else begin
            title_y_nx = 10'(SLIDE_START_Y);
            state_nx   = SLIDE;
          end
        end
      end
      SLIDE: begin
        if (frame_tick) begin
          // 11-bit sum so a large step near the bottom cannot wrap.
          step_sum = {1'b0, title_y} + 11'(SLIDE_STEP);
          if (step_sum >= 11'(TITLE_Y)) begin
            title_y_nx = 10'(TITLE_Y);
            state_nx   = SHOW;
            enter_show = 1'b1;
          end else begin
            title_y_nx = step_sum[9:0];
          end
        end
      end
      SHOW: begin
        if (frame_tick) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt_nx = '0;
            blink_on_nx  = ~blink_on;
          end else begin
            blink_cnt_nx = blink_cnt + BW'(1);
          end
          if (!armed) begin
            arm_cnt_nx = arm_cnt + AW'(1);
            armed_nx   = (arm_cnt_nx == ARM_TGT);
          end
        end
        // Registered armed: a key on the arming tick itself is ignored.
        if (key_press && armed) begin
          dismissed_nx = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (enter_show) begin
      blink_cnt_nx = '0;
      blink_on_nx  = 1'b1;
      arm_cnt_nx   = '0;
      armed_nx     = ARM_AT_ENTRY;
    end
    if (!show) begin
      state_nx     = IDLE;
      dismissed_nx = 1'b0;
    end
  end

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      title_y   <= 10'(SLIDE_START_Y);
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      arm_cnt   <= '0;
      armed     <= 1'b0;
      mode_q    <= 2'd0;
      dismissed <= 1'b0;
      in_text   <= 1'b0;
    end else begin
      state     <= state_nx;
      title_y   <= title_y_nx;
      blink_cnt <= blink_cnt_nx;
      blink_on  <= blink_on_nx;
      arm_cnt   <= arm_cnt_nx;
      armed     <= armed_nx;
      mode_q    <= mode_nx;
      dismissed <= dismissed_nx;
      in_text   <= (state != IDLE) && (title_pix || (prompt_en && prompt_pix));
    end
  end
endmodule

// File: tb/tb_game_screen_overlay.sv
`timescale 1ns/1ps
// Bench for game_screen_overlay with default parameters.
// Expected tuple per sample is {in_text, active, dismissed}.
// Reference pixels (hand-derived from the 5x7 font):
//   (90,y)   "G" row 0 column 1 when title top is y (mode 0, x origin 80)
//   (82,y)   "G" row 0 column 0, dark
//   (123,183) prompt "P" row 0 column 0 (x origin 122, top 182)
//   (50,110) "l" of "Player 2 wins!" row 1 column 2 (x origin -16)
module tb_game_screen_overlay;
  logic       clk_0 = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       frame_tick = 1'b0;
  logic       show = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       key_press = 1'b0;
  logic       in_text;
  logic       active;
  logic       dismissed;

  game_screen_overlay dut (
    .clk_0(clk_0), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .show(show), .mode(mode), .key_press(key_press),
    .in_text(in_text), .active(active), .dismissed(dismissed)
  );

  // ---------------- clock ----------------
  always #5 clk_0 = ~clk_0;

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];
  string      name_q[$];
  logic       chk_req = 1'b0;
  logic       chk_pending = 1'b0;
  logic       async_req = 1'b0;
  logic [2:0] mon_exp;
  string      mon_name;

  // A request issued in one cycle is answered by the outputs after the
  // following rising edge, sampled on the falling edge.
  always @(posedge clk_0) chk_pending <= chk_req;

  always @(negedge clk_0) begin
    if (chk_pending || async_req) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: output sampled with no expected value queued");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        checks++;
        if ({in_text, active, dismissed} !== mon_exp)
          begin
            errors++;
            $display("FAIL %s: got in_text/active/dismissed=%b%b%b expected %b at %0t",
                     mon_name, in_text, active, dismissed, mon_exp, $time);
          end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns just after the next one.
  task automatic step(input bit tick, input bit key, input bit chk,
                      input logic [2:0] exp, input string name);
    frame_tick = tick;
    key_press  = key;
    chk_req    = chk;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(negedge clk_0);
    frame_tick = 1'b0;
    key_press  = 1'b0;
    chk_req    = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'b000, "");
  endtask

  task automatic tick_frame();
    step(1'b1, 1'b0, 1'b0, 3'b000, "");
    idle();
  endtask

  task automatic probe(input int x, input int y, input logic [2:0] exp, input string name);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    step(1'b0, 1'b0, 1'b1, exp, name);
  endtask

  // ---------------- stimulus ----------------
  int         ty;
  logic [2:0] blink_exp;

  initial begin
    @(negedge clk_0);
    @(negedge clk_0);
    rst = 1'b0;

    // Idle after reset, show low for two frames.
    probe(90, 100, 3'b000, "reset_state");
    tick_frame();
    probe(90, 100, 3'b000, "idle_frame1_title");
    probe(123, 183, 3'b000, "idle_frame1_prompt");
    tick_frame();
    probe(90, 100, 3'b000, "idle_frame2_title");

    // Session A: slide in "Game over!", blink, early key, armed key.
    mode = 2'd0;
    show = 1'b1;
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    step(1'b0, 1'b0, 1'b1, 3'b010, "slide_entry");
    probe(90, 0, 3'b110, "title_at_start");
    for (int k = 1; k <= 25; k++) begin
      ty = (4 * k > 99) ? 99 : 4 * k;
      tick_frame();
      probe(90, ty, 3'b110, "title_top_row");
      probe(90, ty - 1, 3'b010, "title_above_top");
      if (k == 24) probe(123, 183, 3'b010, "prompt_off_in_slide");
      if (k == 25) probe(123, 183, 3'b110, "prompt_on_at_show");
    end
    probe(90, 100, 3'b110, "g_pixel_lit");
    probe(82, 100, 3'b010, "g_gap_dark");
    for (int f = 1; f <= 89; f++) begin
      tick_frame();
      if (f == 10) begin
        pixel_x = 10'd90;
        pixel_y = 10'd100;
        step(1'b0, 1'b1, 1'b1, 3'b110, "early_key_ignored");
        probe(90, 100, 3'b110, "still_show_after_early_key");
      end
      if (f == 29 || f == 30 || f == 59 || f == 60 || f == 89) begin
        blink_exp = {((f / 30) % 2) == 0, 2'b10};
        probe(123, 183, blink_exp, "prompt_blink");
      end
    end
    pixel_x = 10'd90;
    pixel_y = 10'd100;
    step(1'b0, 1'b1, 1'b1, 3'b101, "armed_key_dismiss");
    show = 1'b0;
    probe(90, 100, 3'b000, "idle_after_dismiss");

    // Session B: key on the arming tick is ignored, next frame accepted.
    show = 1'b1;
    idle();
    repeat (25) tick_frame();
    repeat (59) tick_frame();
    pixel_x = 10'd90;
    pixel_y = 10'd100;
    step(1'b1, 1'b1, 1'b1, 3'b110, "key_on_arming_tick");
    probe(90, 100, 3'b110, "show_after_arming_tick");
    tick_frame();
    step(1'b0, 1'b1, 1'b1, 3'b101, "key_frame61_dismiss");
    show = 1'b0;
    probe(90, 100, 3'b000, "dismiss_one_cycle");

    // Session C: show dropped in SLIDE, then in SHOW with an armed key.
    show = 1'b1;
    idle();
    repeat (3) tick_frame();
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    show = 1'b0;
    step(1'b0, 1'b0, 1'b1, 3'b000, "show_drop_in_slide");
    probe(0, 0, 3'b000, "idle_after_slide_drop");
    show = 1'b1;
    idle();
    repeat (85) tick_frame();
    probe(90, 100, 3'b110, "armed_show_before_drop");
    show = 1'b0;
    step(1'b0, 1'b1, 1'b1, 3'b100, "show_drop_beats_key");
    probe(90, 100, 3'b000, "no_dismiss_after_drop");

    // Session D: mode latched at entry, mode change during SHOW ignored.
    mode = 2'd2;
    show = 1'b1;
    idle();
    repeat (25) tick_frame();
    mode = 2'd3;
    repeat (3) tick_frame();
    probe(50, 110, 3'b110, "mode2_pixel_kept");
    probe(90, 100, 3'b010, "mode0_pixel_dark");
    probe(50, 110, 3'b110, "mode2_pixel_again");
    idle();

    // Reset mid-SHOW, sampled before any further rising edge.
    @(posedge clk_0);
    #2;
    rst = 1'b1;
    exp_q.push_back(3'b000);
    name_q.push_back("async_reset");
    async_req = 1'b1;
    @(negedge clk_0);
    #1;
    async_req = 1'b0;
    probe(50, 110, 3'b000, "held_in_reset");
    rst = 1'b0;
    show = 1'b0;
    probe(50, 110, 3'b000, "idle_after_reset");

    idle();
    idle();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected values never sampled", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: bench did not complete, checks=%0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
